conv_encoder_framer: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder with frame control, the transmit-side counterpart of the Viterbi decoder's 4-state trellis. It accepts a frame of FRAME_LEN payload bits over a valid/ready handshake and encodes each bit into a 2-bit code symbol. It then appends K-1 = 2 zero tail bits so the encoder ends in state 0, which is the termination the decoder's traceback expects. Symbols leave through a registered, backpressure-capable output stage feeding the channel model / decoder bench.

---
 rtl/conv_encoder_framer.sv | 100 ++++++++++
 tb/tb_conv_encoder_framer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=3 convolutional encoder with frame control and zero-tail termination.
// Symbols leave through a single registered slot that holds steady under backpressure.
module conv_encoder_framer #(
  parameter int unsigned FRAME_LEN = 16,
  parameter logic [2:0]  G0        = 3'b111,
  parameter logic [2:0]  G1        = 3'b101
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_bit,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [1:0] o_sym,
  output logic       o_sym_valid,
  input  logic       i_sym_ready,
  output logic       o_tail,
  output logic       o_frame_done,
  output logic       o_busy
);
  // state | meaning
  // IDLE  | waiting for i_start, output slot may still drain
  // DATA  | accepting FRAME_LEN payload bits
  // TAIL  | flushing two zero bits to return the trellis to state 0
  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  localparam int unsigned   CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);

  state_t        state, state_nxt;
  logic [1:0]    sr;
  logic [CW-1:0] bit_cnt;
  logic          tail_cnt;
  logic          free, accept, tail_load, load, u, last_tail;
  logic [2:0]    taps;

  always_comb begin
    free      = !o_sym_valid || i_sym_ready;
    o_ready   = 1'b0;
    accept    = 1'b0;
    tail_load = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: if (i_start) state_nxt = DATA;
      DATA: begin
        o_ready = free;
        accept  = i_valid && free;
        if (accept && bit_cnt == LAST_BIT) state_nxt = TAIL;
      end
      TAIL: begin
        tail_load = free;
        if (free && tail_cnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load      = accept || tail_load;
  assign u         = accept && i_bit;
  assign taps      = {u, sr};
  assign last_tail = tail_load && tail_cnt;
  assign o_busy    = (state != IDLE) || o_sym_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr           <= 2'b00;
      bit_cnt      <= '0;
      tail_cnt     <= 1'b0;
      o_sym        <= 2'b00;
      o_sym_valid  <= 1'b0;
      o_tail       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= last_tail;
      if (state == IDLE && i_start) begin
        sr      <= 2'b00;
        bit_cnt <= '0;
      end
      if (accept) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) tail_cnt <= 1'b0;
      end
      // one-bit tail counter returns to 0 after the second tail symbol
      if (tail_load) tail_cnt <= ~tail_cnt;
      if (load) begin
        o_sym       <= {^(G0 & taps), ^(G1 & taps)};
        o_tail      <= tail_load;
        o_sym_valid <= 1'b1;
        sr          <= {u, sr[1]};
      end else if (o_sym_valid && i_sym_ready) begin
        o_sym_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_encoder_framer.sv
// Scoreboard bench for conv_encoder_framer: stimulus pushes expected symbols,
// a negedge monitor pops and compares on every consumed symbol.
module tb_conv_encoder_framer;
  localparam int FL = 4;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, bit_in = 1'b0, valid = 1'b0, sym_ready = 1'b1;
  logic ready, sym_valid, tail, frame_done, busy;
  logic [1:0] sym;

  logic b_start = 1'b0, b_bit = 1'b0, b_valid = 1'b0, b_sym_ready = 1'b1;
  logic b_ready, b_sym_valid, b_tail, b_frame_done, b_busy;
  logic [1:0] b_sym;

  conv_encoder_framer #(.FRAME_LEN(FL), .G0(G0), .G1(G1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_bit(bit_in), .i_valid(valid),
    .o_ready(ready), .o_sym(sym), .o_sym_valid(sym_valid), .i_sym_ready(sym_ready),
    .o_tail(tail), .o_frame_done(frame_done), .o_busy(busy));

  conv_encoder_framer #(.FRAME_LEN(1), .G0(G0), .G1(G1)) dut_one (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_bit(b_bit), .i_valid(b_valid),
    .o_ready(b_ready), .o_sym(b_sym), .o_sym_valid(b_sym_valid), .i_sym_ready(b_sym_ready),
    .o_tail(b_tail), .o_frame_done(b_frame_done), .o_busy(b_busy));

  int n_cmp = 0, n_bad = 0, n_frames = 0, done_cnt = 0, cyc = 0, rdy_mode = 0;
  bit sb_on = 1'b1;
  logic [5:0] bp_pat = 6'b101001;
  logic [2:0] exp_q[$];
  logic [2:0] kv[6] = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b101, 3'b111};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Convolution of the zero-padded payload with the generator taps: {tail, g0, g1}.
  function automatic logic [2:0] ref_sym(input logic [15:0] bits, input int len, input int k);
    logic x0, x1, x2;
    x0 = (k < len) ? bits[k] : 1'b0;
    x1 = (k >= 1 && k - 1 < len) ? bits[k-1] : 1'b0;
    x2 = (k >= 2 && k - 2 < len) ? bits[k-2] : 1'b0;
    return {k >= len,
            (G0[2] & x0) ^ (G0[1] & x1) ^ (G0[0] & x2),
            (G1[2] & x0) ^ (G1[1] & x1) ^ (G1[0] & x2)};
  endfunction

  task automatic push_model(input logic [15:0] bits);
    for (int k = 0; k < FL + 2; k++) exp_q.push_back(ref_sym(bits, FL, k));
  endtask

  task automatic push_known();
    for (int k = 0; k < 6; k++) exp_q.push_back(kv[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      0: sym_ready = 1'b1;
      1: sym_ready = bp_pat[cyc % 6];
      2: sym_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic send_frame(input logic [15:0] bits, input bit bubbles, input bit poke);
    int k = 0;
    int guard = 0;
    logic acc;
    n_frames++;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (k < FL && guard < 400) begin
      valid  = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      bit_in = valid ? bits[k] : 1'($urandom_range(0, 1));
      start  = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      acc = valid & ready;
      tick();
      if (acc) k++;
      guard++;
    end
    check("payload_accepted", 32'(k), 32'(FL));
    while (!frame_done && guard < 400) begin
      valid  = (bubbles || poke) ? 1'($urandom_range(0, 1)) : 1'b0;
      bit_in = 1'($urandom_range(0, 1));
      start  = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check("tail_ready", 32'(ready), 32'd0);
      tick();
      guard++;
    end
    valid = 1'b0;
    start = 1'b0;
    check("frame_done_seen", 32'(frame_done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd1);
  endtask

  task automatic drain();
    int g = 0;
    rdy_mode = 0;
    sym_ready = 1'b1;
    while (busy && g < 200) begin
      tick();
      g++;
    end
    check("drain_idle", 32'(busy), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [2:0] prev_ent = 3'b000, mon_e;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst || !sb_on) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) check("hold", 32'({sym_valid, tail, sym}), 32'({1'b1, prev_ent}));
      if (sym_valid && !sym_ready) check("stall_ready", 32'(ready), 32'd0);
      if (frame_done) begin
        check("done_with_tail", 32'({sym_valid, tail}), 32'd3);
        done_cnt <= done_cnt + 1;
      end
      if (sym_valid && sym_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_symbol: got %b, expected none", {tail, sym});
        end else begin
          mon_e = exp_q.pop_front();
          check("symbol", 32'({tail, sym}), 32'(mon_e));
        end
      end
      prev_stall <= sym_valid && !sym_ready;
      prev_ent   <= {tail, sym};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    rdy_mode = 0;
    tick();
    tick();
    check("reset_outputs", 32'({sym, sym_valid, tail, frame_done, ready, busy}), 32'd0);
    check("reset_one_outputs", 32'({b_sym, b_sym_valid, b_tail, b_frame_done, b_ready, b_busy}), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_ready", 32'(ready), 32'd0);

    // known vector, free-flowing output
    push_known();
    send_frame(16'b1101, 1'b0, 1'b0);
    tick();
    check("busy_falls", 32'(busy), 32'd0);

    // known vector under backpressure
    rdy_mode = 1;
    push_known();
    send_frame(16'b1101, 1'b0, 1'b0);
    drain();

    // known vector with input bubbles
    push_known();
    send_frame(16'b1101, 1'b1, 1'b0);
    drain();

    // ignored starts, then a back-to-back frame
    rdy_mode = 2;
    bits = 16'($urandom);
    push_model(bits);
    send_frame(bits, 1'b0, 1'b1);
    bits = 16'($urandom);
    push_model(bits);
    send_frame(bits, 1'b1, 1'b0);
    drain();

    // mid-frame reset with a stalled symbol pending
    sb_on = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1;
    bit_in = 1'b1;
    tick();
    bit_in = 1'b0;
    tick();
    valid = 1'b0;
    rdy_mode = 3;
    sym_ready = 1'b0;
    tick();
    check("pending_before_reset", 32'(sym_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("midframe_reset", 32'({sym, sym_valid, tail, frame_done, ready, busy}), 32'd0);
    rst = 1'b0;
    rdy_mode = 0;
    sym_ready = 1'b1;
    tick();
    sb_on = 1'b1;
    push_known();
    send_frame(16'b1101, 1'b0, 1'b0);
    drain();

    // randomized frames, including an all-zero payload
    for (int f = 0; f < 20; f++) begin
      rdy_mode = $urandom_range(0, 2);
      bits = (f == 5) ? 16'h0 : 16'($urandom);
      push_model(bits);
      send_frame(bits, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) tick();
    end
    drain();
    tick();
    check("frame_done_count", 32'(done_cnt), 32'(n_frames));

    // FRAME_LEN = 1 boundary: bit 1 -> 11, 10, 11 with tail pattern 0,1,1
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_valid = 1'b1;
    b_bit = 1'b1;
    #1;
    check("one_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("one_symbol", 32'({b_sym_valid, b_tail, b_sym}), 32'({1'b1, ref_sym(16'h1, 1, k)}));
      check("one_done", 32'(b_frame_done), 32'(k == 2));
      if (k > 0) check("one_ready_tail", 32'(b_ready), 32'd0);
      tick();
    end
    check("one_idle", 32'(b_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
